// File: rtl/bcd_timer_mux.sv
// bcd_timer_mux: multi-digit BCD up/down timer with a built-in seven-segment scan driver.
// Define BCD_TIMER_BLANK_EN for leading-zero blanking; the direction input is count_type ("type" is reserved).
`timescale 1ns/1ps
module bcd_timer_mux #(
   parameter int DIGITS   = 2,
   parameter int CLK_HZ   = 50000000,
   parameter int TICK_HZ  = 1,
   parameter int SCAN_DIV = 17
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                load,
   input  logic                count_type,
   input  logic                en,
   input  logic [4*DIGITS-1:0] in,
   output logic [4*DIGITS-1:0] q,
   output logic                tc,
   output logic [6:0]          a_to_g,
   output logic [DIGITS-1:0]   an
);
   localparam int PRE_N = CLK_HZ / TICK_HZ;
   localparam int PRE_W = $clog2(PRE_N);
   localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRE_N - 1);
   localparam logic [SEL_W:0]    DIG_L   = (SEL_W + 1)'(DIGITS);
   localparam logic [DIGITS-1:0] AN_RST  = ~(DIGITS'(1'b1));

   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      logic [3:0] r;
      if (d > 4'd9) r = 4'd9;
      else          r = d;
      return r;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b0000001;
         4'd1:    g = 7'b1001111;
         4'd2:    g = 7'b0010010;
         4'd3:    g = 7'b0000110;
         4'd4:    g = 7'b1001100;
         4'd5:    g = 7'b0100100;
         4'd6:    g = 7'b0100000;
         4'd7:    g = 7'b0001111;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0000100;
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   logic [PRE_W-1:0]    pre_r;
   logic [SCAN_DIV-1:0] scan_r;
   logic [4*DIGITS-1:0] q_r;
   logic                tc_r;
   logic [6:0]          seg_r;
   logic [DIGITS-1:0]   an_r;

   logic [4*DIGITS-1:0] q_next_s;
   logic [4*DIGITS-1:0] load_val_s;
   logic                carry_s;
   logic [3:0]          dig_s;
   logic                tick_s;
   logic [SEL_W-1:0]    sel_s;
   logic [SEL_W-1:0]    k_s;
   logic [3:0]          cur_dig_s;
   logic [DIGITS-1:0]   blank_s;
   logic [6:0]          seg_s;

   assign tick_s = en && (pre_r == PRE_MAX);

   // Ripple BCD step in the selected direction, plus the clamped load value
   always_comb begin
      q_next_s   = q_r;
      load_val_s = '0;
      carry_s    = 1'b1;
      dig_s      = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig_s = q_r[4*i +: 4];
         load_val_s[4*i +: 4] = clamp_digit(in[4*i +: 4]);
         if (!carry_s) begin
            q_next_s[4*i +: 4] = dig_s;
         end else if (count_type) begin
            if (dig_s == 4'd0) begin
               q_next_s[4*i +: 4] = 4'd9;
            end else begin
               q_next_s[4*i +: 4] = dig_s - 4'd1;
               carry_s = 1'b0;
            end
         end else begin
            if (dig_s >= 4'd9) begin
               q_next_s[4*i +: 4] = 4'd0;
            end else begin
               q_next_s[4*i +: 4] = dig_s + 4'd1;
               carry_s = 1'b0;
            end
         end
      end
   end

   // Prescaler, count register and terminal-count pulse; load overrides any same-cycle tick
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pre_r <= '0;
         q_r   <= '0;
         tc_r  <= 1'b0;
      end else if (load) begin
         pre_r <= '0;
         q_r   <= load_val_s;
         tc_r  <= 1'b0;
      end else begin
         if (en) pre_r <= (pre_r == PRE_MAX) ? '0 : pre_r + PRE_W'(1);
         else    pre_r <= pre_r;
         if (tick_s) begin
            q_r  <= q_next_s;
            tc_r <= carry_s;
         end else begin
            q_r  <= q_r;
            tc_r <= 1'b0;
         end
      end
   end

   // Digit select from the top scan bits, folded back into range for non-power-of-two DIGITS
   always_comb begin
      sel_s = scan_r[SCAN_DIV-1 -: SEL_W];
      if ({1'b0, sel_s} >= DIG_L) k_s = SEL_W'({1'b0, sel_s} - DIG_L);
      else                        k_s = sel_s;
      cur_dig_s = q_r[{k_s, 2'b00} +: 4];
   end

`ifdef BCD_TIMER_BLANK_EN
   logic zero_run_s;

   // A digit blanks when it and every higher digit are zero; digit 0 always shows
   always_comb begin
      zero_run_s = 1'b1;
      blank_s    = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (q_r[4*i +: 4] != 4'd0) zero_run_s = 1'b0;
         else                       zero_run_s = zero_run_s;
         blank_s[i] = zero_run_s;
      end
   end
`else
   assign blank_s = '0;
`endif

   // Segment pattern for the digit currently being scanned
   always_comb begin
      if (blank_s[k_s]) seg_s = 7'b1111111;
      else              seg_s = glyph(cur_dig_s);
   end

   // Free-running scan counter and registered display outputs (one cycle behind q)
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         scan_r <= '0;
         an_r   <= AN_RST;
         seg_r  <= 7'b0000001;
      end else begin
         scan_r <= scan_r + SCAN_DIV'(1);
         an_r   <= ~(DIGITS'(1'b1) << k_s);
         seg_r  <= seg_s;
      end
   end

   assign q      = q_r;
   assign tc     = tc_r;
   assign a_to_g = seg_r;
   assign an     = an_r;
endmodule

// File: tb/tb_bcd_timer_mux.sv
// Scoreboard bench for bcd_timer_mux (DIGITS=2, 8 clocks per tick, 3-bit scan counter).
`timescale 1ns/1ps
module tb_bcd_timer_mux;
   typedef struct {
      logic [7:0] q;
      logic       tc;
      int         cyc;
      int         id;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic       count_type = 1'b0;
   logic       en = 1'b1;
   logic [7:0] in = 8'h00;
   logic [7:0] q;
   logic       tc;
   logic [6:0] a_to_g;
   logic [1:0] an;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic [7:0] prev_q = 8'h00;
   exp_t sb[$];

`ifdef BCD_TIMER_BLANK_EN
   localparam logic [6:0] SEG_D1 = 7'b1111111;
`else
   localparam logic [6:0] SEG_D1 = 7'b0000001;
`endif

   bcd_timer_mux #(.DIGITS(2), .CLK_HZ(8), .TICK_HZ(1), .SCAN_DIV(3)) dut (
      .clk(clk), .clr(clr), .load(load), .count_type(count_type), .en(en),
      .in(in), .q(q), .tc(tc), .a_to_g(a_to_g), .an(an)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] qv, input logic tcv, input int c, input int id);
      exp_t e;
      e.q = qv; e.tc = tcv; e.cyc = c; e.id = id;
      sb.push_back(e);
   endtask

   task automatic at_cycle(input int c);
      while (cyc < c) @(negedge clk);
      #2;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expected q changes not seen, next id %0d", sb.size(), sb[0].id);
         sb.delete();
      end
   endtask

   // Monitor: every q change must match the head of the scoreboard; tc must be idle otherwise
   always @(negedge clk) begin
      exp_t e;
      if (!clr) begin
         prev_q = q;
      end else if (q !== prev_q) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change: q=%h tc=%b cycle %0d, no change expected", q, tc, cyc);
         end else begin
            e = sb.pop_front();
            if (q !== e.q || tc !== e.tc || cyc != e.cyc) begin
               failures++;
               $display("FAIL change_%0d: got q=%h tc=%b cycle %0d, expected q=%h tc=%b cycle %0d",
                        e.id, q, tc, cyc, e.q, e.tc, e.cyc);
            end
         end
         prev_q = q;
      end else begin
         checks++;
         if (tc !== 1'b0) begin
            failures++;
            $display("FAIL tc_idle: got tc=%b expected 0 with q=%h held (cycle %0d)", tc, q, cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, r2, l, d, e, s;
      logic hi;
      // Reset state while clr is held low
      repeat (3) @(negedge clk);
      #2;
      chk("rst_q", q, 8'h00);
      chk("rst_tc", {7'b0, tc}, 8'h00);
      chk("rst_an", {6'b0, an}, 8'h02);
      chk("rst_seg", {1'b0, a_to_g}, 8'h01);
      clr = 1'b1;
      r = cyc;
      push(8'h01, 1'b0, r + 8, 1);

      // Asynchronous reset mid-count, then a full prescaler period after release
      at_cycle(r + 11);
      clr = 1'b0;
      #1;
      chk("mid_rst_q", q, 8'h00);
      chk("mid_rst_tc", {7'b0, tc}, 8'h00);
      chk("mid_rst_an", {6'b0, an}, 8'h02);
      chk("mid_rst_seg", {1'b0, a_to_g}, 8'h01);
      at_cycle(r + 14);
      clr = 1'b1;
      r2 = cyc;
      push(8'h01, 1'b0, r2 + 8, 2);
      drain();

      // Up wrap 98 -> 99 -> 00 with tc on the wrap
      at_cycle(cyc + 1);
      l = cyc;
      load = 1'b1; in = 8'h98; count_type = 1'b0;
      push(8'h98, 1'b0, l + 1, 3);
      push(8'h99, 1'b0, l + 9, 4);
      push(8'h00, 1'b1, l + 17, 5);
      at_cycle(l + 1);
      load = 1'b0;
      drain();

      // Down wrap 01 -> 00 -> 99, then switch to up: 99 -> 00 with tc
      at_cycle(cyc + 1);
      d = cyc;
      load = 1'b1; in = 8'h01; count_type = 1'b1;
      push(8'h01, 1'b0, d + 1, 6);
      push(8'h00, 1'b0, d + 9, 7);
      push(8'h99, 1'b1, d + 17, 8);
      at_cycle(d + 1);
      load = 1'b0;
      at_cycle(d + 18);
      count_type = 1'b0;
      push(8'h00, 1'b1, d + 25, 9);

      // Load coincident with a tick: clamp FA -> 99, tick discarded, full period follows
      at_cycle(d + 32);
      load = 1'b1; in = 8'hFA;
      push(8'h99, 1'b0, d + 33, 10);
      push(8'h00, 1'b1, d + 41, 11);
      at_cycle(d + 33);
      load = 1'b0;
      drain();

      // Enable hold for 20 cycles: prescaler resumes where it froze
      at_cycle(cyc + 1);
      e = cyc;
      load = 1'b1; in = 8'h42;
      push(8'h42, 1'b0, e + 1, 12);
      at_cycle(e + 1);
      load = 1'b0;
      at_cycle(e + 4);
      en = 1'b0;
      at_cycle(e + 24);
      en = 1'b1;
      push(8'h43, 1'b0, e + 29, 13);
      drain();

      // Scan of q=05 with counting stopped
      at_cycle(cyc + 1);
      s = cyc;
      load = 1'b1; in = 8'h05; en = 1'b0;
      push(8'h05, 1'b0, s + 1, 14);
      at_cycle(s + 1);
      load = 1'b0;
      for (int t = s + 2; t <= s + 17; t++) begin
         at_cycle(t);
         hi = (((t - 1 - r2) % 8) >= 4);
         chk("scan_an", {6'b0, an}, hi ? 8'h01 : 8'h02);
         chk("scan_seg", {1'b0, a_to_g}, hi ? {1'b0, SEG_D1} : 8'h24);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bcd_timer_mux.md
Name: bcd_timer_mux

Overview:
Parametrised multi-digit BCD timer with a built-in seven-segment scan driver. It is the next generation of the board-level timer: one block replaces the separate 1 Hz divider, two-digit counter and display driver. It adds a configurable digit count, a run enable, a terminal-count pulse and range clamping on load. It sits directly under the board top level, driving the anode and segment pins.

Parameters:
DIGITS, 2, number of BCD digits counted and displayed (1..8).
CLK_HZ, 50000000, input clock frequency.
TICK_HZ, 1, count rate. CLK_HZ/TICK_HZ must be an integer of at least 2.
SCAN_DIV, 17, refresh counter width. Digit select = top log2(DIGITS) bits, rounded up.

Ports:
clk  in  1  system clock; all logic is in this single clock domain.
clr  in  1  reset, asynchronous, active-low (0 = reset).
load  in  1  synchronous load strobe.
type  in  1  count direction: 0 = up, 1 = down.
en  in  1  run enable: 1 = count on ticks, 0 = hold.
in  in  4*DIGITS  load value, BCD, digit 0 in bits [3:0].
q  out  4*DIGITS  current BCD count.
tc  out  1  one-cycle pulse on each wrap.
a_to_g  out  7  segments a..g, bit 6 = a, active-low.
an  out  DIGITS  digit enables, active-low, one-hot-low.

Behaviour:
Reset (clr=0, async) clears:
- prescaler = 0
- scan counter = 0
- q = 0
- tc = 0
- an = all ones except bit 0 = 0
- a_to_g = 7'b0000001 (glyph "0")

Prescaler:
- Counts 0..CLK_HZ/TICK_HZ-1 and wraps.
- Internal tick = 1 for one cycle when the prescaler is at its terminal value and en=1.
- When en=0 the prescaler freezes; it does not reset.

Priority per clk edge: load > tick > hold.
- load=1:
  - q <= in, with each digit above 9 clamped to 9.
  - Prescaler cleared to 0.
  - tc = 0.
  - Any tick in the same cycle is discarded.
- tick with type=0 (up):
  - Ripple BCD increment; digit 9 goes to 0 with a carry.
  - All-9s wraps to all-0s and tc = 1 in that cycle.
- tick with type=1 (down):
  - Ripple BCD decrement; digit 0 goes to 9 with a borrow.
  - All-0s wraps to all-9s and tc = 1.
- Latency: q updates on the edge where the tick is sampled. tc is registered, aligned with the q change, and high for exactly 1 cycle.
- A type change takes effect on the next tick. There is no glitch on q.

Scan:
- The free-running SCAN_DIV-bit counter is unaffected by load and en.
- Digit select k = top bits, modulo DIGITS. For non-power-of-two DIGITS, select values >= DIGITS wrap to k - DIGITS.
- an and a_to_g are registered and updated from q every cycle: an[k] = 0, a_to_g = glyph(q digit k).
- The display lags q by 1 cycle.
- Glyph table, active-low a..g:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- No values above 9 reach the table; a default case drives all segments off (1111111).

Reset mid-count: state is cleared immediately. After release, counting restarts from a full prescaler period.

Optional Feature:
Macro BCD_TIMER_BLANK_EN.
- Defined: leading-zero blanking. A digit k > 0 displays 1111111 when it and every higher digit are 0. Digit 0 is never blanked. The an scan is unchanged.
- Undefined: every digit shows its glyph, including leading zeros.
- q and tc are identical in both builds.

Test Plan:
- Test parameters: DIGITS=2, CLK_HZ=8, TICK_HZ=1, SCAN_DIV=3.
- Reset: hold clr=0 mid-count -> q=00, tc=0, an=2'b10, a_to_g=0000001 asynchronously. After release, first increment occurs 8 cycles later.
- Up wrap: load 8'h98, en=1, type=0 -> q goes 98, 99, 00 at 8-cycle spacing. tc=1 for exactly the single cycle q becomes 00.
- Down wrap and type switch: load 8'h01, type=1 -> q goes 00, then 99 with tc pulse. Set type=0 -> next tick q=00 with tc pulse.
- Load priority and clamp: assert load with in=8'hFA on the same cycle as a tick -> q=99 (both digits clamped), no increment, no tc. Next change occurs 8 cycles after the load.
- Enable hold: en=0 for 20 cycles at q=42 -> q stays 42 and tc stays 0. Re-enable -> increment occurs after the remaining prescaler count, not a full period.
- Scan and blanking: q=05 -> an alternates 10/01 every 4 cycles; digit 1 shows 0000001 without the macro and 1111111 with BCD_TIMER_BLANK_EN; digit 0 shows 0100100.
